// File: rtl/channel_iir_pkg.sv
// Shared types, coefficient slot map and arithmetic helpers for the
// time-multiplexed parallel-form IIR channel model.
package channel_iir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int unsigned B0 = 0;
  localparam int unsigned B1 = 1;
  localparam int unsigned A1 = 2;
  localparam int unsigned A2 = 3;

  // Round half up, then arithmetic shift right by frac.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int unsigned frac);
    logic signed [63:0] half;
    if (frac == 0) return v;
    half = 64'sd1 <<< (frac - 1);
    return (v + half) >>> frac;
  endfunction

  // Clamp to the two's-complement range of a dw-bit signed word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/channel_iir_sec_mac.sv
// Combinational second-order section step: four-product MAC, rounding to
// the sample grid and saturation to the sample width.
module channel_iir_sec_mac
  import channel_iir_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 18,
  parameter int FRAC = 14,
  parameter int AW   = 40
) (
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] x1_i,
  input  logic signed [DW-1:0] y1_i,
  input  logic signed [DW-1:0] y2_i,
  input  logic signed [CW-1:0] b0_i,
  input  logic signed [CW-1:0] b1_i,
  input  logic signed [CW-1:0] a1_i,
  input  logic signed [CW-1:0] a2_i,
  output logic signed [DW-1:0] ys_o,
  output logic                 sat_o
);

  logic signed [AW-1:0] v;
  logic signed [63:0]   rnd;
  logic signed [63:0]   clip;

  always_comb begin
    v = AW'(b0_i) * AW'(x_i) + AW'(b1_i) * AW'(x1_i)
      - AW'(a1_i) * AW'(y1_i) - AW'(a2_i) * AW'(y2_i);
    rnd   = round_shift(64'(v), FRAC);
    clip  = sat_dw(rnd, DW);
    sat_o = (clip != rnd);
    ys_o  = clip[DW-1:0];
  end

endmodule

// File: rtl/channel_iir_tdm.sv
// Parallel-form IIR channel: NSEC biquad sections share one MAC, evaluated
// one section per cycle, and their outputs are summed into one sample.
module channel_iir_tdm
  import channel_iir_pkg::*;
#(
  parameter int NSEC = 4,
  parameter int DW   = 16,
  parameter int CW   = 18,
  parameter int FRAC = 14,
  parameter int AW   = 40,
  localparam int ADDR_W = $clog2(4 * NSEC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_sat,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_err,
  input  logic                 hist_clr
);

  localparam int NCOEF = 4 * NSEC;
  localparam int SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;

  state_t state_q, state_d;

  logic signed [DW-1:0] x_q;
  logic signed [DW-1:0] x1_q;
  logic signed [DW-1:0] y1_q [NSEC];
  logic signed [DW-1:0] y2_q [NSEC];
  logic signed [CW-1:0] coef_q [NCOEF];
  logic [SEC_W-1:0]     sec_q;
  logic signed [AW-1:0] acc_q;
  logic                 sat_q;
  logic signed [DW-1:0] out_data_q;
  logic                 out_sat_q;
  logic                 cfg_err_q;

  logic                 accept;
  logic                 clr_ok;
  logic                 addr_ok;
  logic                 cfg_ok;
  logic                 cfg_bad;
  logic                 last_sec;

  logic signed [DW-1:0] y1_sel, y2_sel;
  logic signed [CW-1:0] b0_sel, b1_sel, a1_sel, a2_sel;
  logic signed [DW-1:0] ys;
  logic                 mac_sat;
  logic signed [AW-1:0] acc_nx;
  logic signed [63:0]   out_clip;
  logic                 out_ovf;

  // A same-cycle hist_clr wins over in_valid, so that sample is left pending.
  always_comb begin
    accept   = (state_q == IDLE) && in_valid && !hist_clr;
    clr_ok   = (state_q == IDLE) && hist_clr;
    addr_ok  = (32'(cfg_addr) < NCOEF);
    cfg_ok   = cfg_we && (state_q == IDLE) && !accept && addr_ok;
    cfg_bad  = (cfg_we && !cfg_ok) || (hist_clr && (state_q != IDLE));
    last_sec = (sec_q == SEC_W'(NSEC - 1));
  end

  always_comb begin
    y1_sel = '0;
    y2_sel = '0;
    b0_sel = '0;
    b1_sel = '0;
    a1_sel = '0;
    a2_sel = '0;
    for (int k = 0; k < NSEC; k++) begin
      if (sec_q == SEC_W'(k)) begin
        y1_sel = y1_q[k];
        y2_sel = y2_q[k];
        b0_sel = coef_q[4*k + B0];
        b1_sel = coef_q[4*k + B1];
        a1_sel = coef_q[4*k + A1];
        a2_sel = coef_q[4*k + A2];
      end
    end
  end

  channel_iir_sec_mac #(
    .DW   (DW),
    .CW   (CW),
    .FRAC (FRAC),
    .AW   (AW)
  ) u_mac (
    .x_i   (x_q),
    .x1_i  (x1_q),
    .y1_i  (y1_sel),
    .y2_i  (y2_sel),
    .b0_i  (b0_sel),
    .b1_i  (b1_sel),
    .a1_i  (a1_sel),
    .a2_i  (a2_sel),
    .ys_o  (ys),
    .sat_o (mac_sat)
  );

  always_comb begin
    acc_nx   = acc_q + AW'(ys);
    out_clip = sat_dw(64'(acc_nx), DW);
    out_ovf  = (out_clip != 64'(acc_nx));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_sec)  state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      x1_q       <= '0;
      sec_q      <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      for (int k = 0; k < NSEC; k++) begin
        y1_q[k] <= '0;
        y2_q[k] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) coef_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_bad;

      for (int i = 0; i < NCOEF; i++) begin
        if (cfg_ok && (cfg_addr == ADDR_W'(i))) coef_q[i] <= cfg_data;
      end

      if (clr_ok) begin
        x1_q <= '0;
        for (int k = 0; k < NSEC; k++) begin
          y1_q[k] <= '0;
          y2_q[k] <= '0;
        end
      end

      if (accept) begin
        x_q   <= in_data;
        sec_q <= '0;
        acc_q <= '0;
        sat_q <= 1'b0;
      end

      // One section per RUN cycle; the final section also publishes the sum.
      if (state_q == RUN) begin
        for (int k = 0; k < NSEC; k++) begin
          if (sec_q == SEC_W'(k)) begin
            y2_q[k] <= y1_q[k];
            y1_q[k] <= ys;
          end
        end
        acc_q <= acc_nx;
        sat_q <= sat_q | mac_sat;
        sec_q <= sec_q + 1'b1;
        if (last_sec) begin
          x1_q       <= x_q;
          out_data_q <= out_clip[DW-1:0];
          out_sat_q  <= sat_q | mac_sat | out_ovf;
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_channel_iir_tdm.sv
// Directed bench for channel_iir_tdm with a scoreboard fed by a reference
// model of the parallel-form filter.
module tb_channel_iir_tdm;

  localparam int NSEC = 4;
  localparam int DW   = 16;
  localparam int CW   = 18;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;
  logic                 cfg_we = 1'b0;
  logic [3:0]           cfg_addr = '0;
  logic signed [CW-1:0] cfg_data = '0;
  logic                 cfg_err;
  logic                 hist_clr = 1'b0;

  logic                 in_ready3, out_valid3, out_sat3, c3_err;
  logic signed [DW-1:0] out_data3;
  logic                 c3_we = 1'b0;
  logic [3:0]           c3_addr = '0;

  always #5 clk = ~clk;

  channel_iir_tdm #(.NSEC(NSEC), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .hist_clr(hist_clr)
  );

  // Three-section instance: leaves spare address codes for range checks.
  channel_iir_tdm #(.NSEC(3), .DW(DW), .CW(CW)) dut3 (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(in_ready3), .in_data(16'sd0),
    .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3), .out_sat(out_sat3),
    .cfg_we(c3_we), .cfg_addr(c3_addr), .cfg_data(18'sd5), .cfg_err(c3_err),
    .hist_clr(1'b0)
  );

  typedef struct { longint d; bit s; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;

  int mc [16];
  int mx1;
  int my1 [NSEC];
  int my2 [NSEC];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampw(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_clr_hist();
    mx1 = 0;
    for (int k = 0; k < NSEC; k++) begin my1[k] = 0; my2[k] = 0; end
  endtask

  task automatic model_reset();
    model_clr_hist();
    for (int i = 0; i < 16; i++) mc[i] = 0;
  endtask

  task automatic model_step(input int x, output longint y, output bit s);
    longint acc, v, r, ys;
    acc = 0;
    s = 1'b0;
    for (int k = 0; k < NSEC; k++) begin
      v = longint'(mc[4*k]) * x + longint'(mc[4*k+1]) * mx1
        - longint'(mc[4*k+2]) * my1[k] - longint'(mc[4*k+3]) * my2[k];
      r = (v + 8192) >>> 14;
      ys = clampw(r);
      if (ys != r) s = 1'b1;
      my2[k] = my1[k];
      my1[k] = int'(ys);
      acc += ys;
    end
    mx1 = x;
    y = clampw(acc);
    if (y != acc) s = 1'b1;
  endtask

  task automatic wait_valid(inout int n);
    while (!out_valid && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    e = '{d: -99999, s: 1'b0};
    if (q.size() > 0) e = q.pop_front();
    chk({tag, "_data"}, $signed(out_data), e.d);
    chk({tag, "_sat"}, out_sat, longint'(e.s));
  endtask

  task automatic drive_and_check(input int x, input string tag);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(x);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    chk({tag, "_accepted"}, in_ready, 0);
    wait_valid(n);
    chk({tag, "_latency"}, n, NSEC + 1);
    pop_chk(tag);
  endtask

  task automatic send(input int x, input string tag);
    longint y; bit s;
    model_step(x, y, s);
    q.push_back('{d: y, s: s});
    drive_and_check(x, tag);
  endtask

  task automatic send_exp(input int x, input longint ey, input bit es, input string tag);
    longint y; bit s;
    model_step(x, y, s);
    q.push_back('{d: ey, s: es});
    drive_and_check(x, tag);
  endtask

  task automatic cfg_wr(input int idx, input int val);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 4'(idx);
    cfg_data = CW'(val);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_write_ok", cfg_err, 0);
    mc[idx] = val;
  endtask

  task automatic hclr();
    @(negedge clk);
    hist_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hist_clr = 1'b0;
    model_clr_hist();
  endtask

  initial begin
    int n;
    bit seen;
    longint y;
    bit s;
    int vals [8] = '{1200, -3400, 5000, 0, -7000, 2500, 8000, -150};

    // reset, with a sample offered throughout
    rst = 1'b1; in_valid = 1'b1; in_data = 16'sd123;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle", in_ready, 1);
    chk("post_rst_no_out", out_valid, 0);

    // passthrough
    cfg_wr(0, 16384);
    send_exp(1000, 1000, 1'b0, "pass");

    // single pole at 0.5
    cfg_wr(2, -8192);
    hclr();
    send_exp(16384, 16384, 1'b0, "pole0");
    send_exp(0, 8192, 1'b0, "pole1");
    send_exp(0, 4096, 1'b0, "pole2");
    send_exp(0, 2048, 1'b0, "pole3");
    hclr();
    send_exp(0, 0, 1'b0, "pole_clr");

    // saturation both directions
    cfg_wr(2, 0);
    cfg_wr(0, 32768);
    cfg_wr(4, 16384);
    hclr();
    send_exp(20000, 32767, 1'b1, "sat_pos");
    send_exp(-20000, -32768, 1'b1, "sat_neg");

    // all four sections with every coefficient slot in use
    cfg_wr(0, 8192);   cfg_wr(1, 4096);   cfg_wr(2, -4096);  cfg_wr(3, 2048);
    cfg_wr(4, -6000);  cfg_wr(5, 3000);   cfg_wr(6, 5000);   cfg_wr(7, -3000);
    cfg_wr(8, 1000);   cfg_wr(9, 0);      cfg_wr(10, 0);     cfg_wr(11, 1500);
    cfg_wr(12, 0);     cfg_wr(13, -12000); cfg_wr(14, -10000); cfg_wr(15, 4000);
    hclr();
    for (int i = 0; i < 8; i++) send(vals[i], "mix");

    // hist_clr beats a same-cycle in_valid
    @(negedge clk);
    hist_clr = 1'b1; in_valid = 1'b1; in_data = 16'sd555;
    @(posedge clk);
    @(negedge clk);
    hist_clr = 1'b0; in_valid = 1'b0;
    model_clr_hist();
    chk("hclr_prio_not_accepted", in_ready, 1);
    chk("hclr_idle_no_err", cfg_err, 0);
    send(4321, "after_hclr");

    // rejected writes and clears while busy
    model_step(2222, y, s);
    q.push_back('{d: y, s: s});
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd2222;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 18'sd777;
    @(posedge clk);
    @(negedge clk);
    chk("cfg_same_cycle_err", cfg_err, 1);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cfg_in_run_err", cfg_err, 1);
    cfg_we = 1'b0; hist_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hclr_in_run_err", cfg_err, 1);
    hist_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("cfg_err_pulse_end", cfg_err, 0);
    n = 4;
    wait_valid(n);
    chk("busy_latency", n, NSEC + 1);
    pop_chk("busy");
    send(-1500, "coef_unchanged");

    // out-of-range address on the three-section instance
    @(negedge clk);
    c3_we = 1'b1; c3_addr = 4'd12;
    @(posedge clk);
    @(negedge clk);
    chk("addr_range_err", c3_err, 1);
    c3_addr = 4'd11;
    @(posedge clk);
    @(negedge clk);
    chk("addr_last_ok", c3_err, 0);
    c3_we = 1'b0;

    // backpressure
    model_step(500, y, s);
    q.push_back('{d: y, s: s});
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd500;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    wait_valid(n);
    chk("bp_latency", n, NSEC + 1);
    pop_chk("bp_first");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'sd77;
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_data", $signed(out_data), y);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    send(-900, "after_bp");

    // reset two cycles into RUN
    send(3000, "pre_abort");
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd1234;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_out", seen, 0);
    chk("abort_idle", in_ready, 1);
    cfg_wr(0, 16384);
    cfg_wr(1, 16384);
    cfg_wr(2, -8192);
    send_exp(0, 0, 1'b0, "abort_hist0");
    send_exp(1000, 1000, 1'b0, "abort_coef");
    send_exp(0, 1500, 1'b0, "abort_x1y1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
